// File: rtl/log_uart_dumper.sv
// log_uart_dumper: reads N consecutive log entries from the access-log BRAM
// and streams each one MSB-first as bytes over a valid/ready interface.
`default_nettype none

module log_uart_dumper #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [ADDR_WIDTH-1:0] log_addr,
  output logic                  log_rd,
  input  logic [DATA_WIDTH-1:0] log_data,
  input  logic                  log_data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [IDX_W-1:0]   C_IDX_LAST = IDX_W'(NB - 1);
  localparam logic [ADDR_WIDTH:0] C_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] C_ONE     = (ADDR_WIDTH + 1)'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  logic [2:0]            state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [ADDR_WIDTH:0]   rem_q,       rem_d;
  logic [DATA_WIDTH-1:0] entry_q,     entry_d;
  logic [IDX_W-1:0]      idx_q,       idx_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  by_abort_q,  by_abort_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  aborted_q,   aborted_d;
  logic                  log_rd_q,    log_rd_d;
  logic                  tx_valid_q,  tx_valid_d;
  logic [7:0]            tx_data_q,   tx_data_d;

  logic                  w_abort;
  logic                  w_xfer;
  logic [ADDR_WIDTH:0]   w_count_clamped;
  logic [7:0]            w_byte_sel;

  assign w_count_clamped = (count > C_DEPTH) ? C_DEPTH : count;
  assign w_abort         = abort | abort_pend_q;
  assign w_xfer          = tx_valid_q & tx_ready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    entry_d      = entry_q;
    idx_d        = idx_q;
    abort_pend_d = abort_pend_q | abort;
    by_abort_d   = by_abort_q;

    case (state_q)
      S_IDLE: begin
        // abort is not sampled here, even when it coincides with start
        abort_pend_d = 1'b0;
        by_abort_d   = 1'b0;
        if (start) begin
          addr_d  = base_addr;
          rem_d   = w_count_clamped;
          state_d = (w_count_clamped == '0) ? S_FINISH : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (w_abort) begin
          state_d    = S_FINISH;
          by_abort_d = 1'b1;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (w_abort) begin
          state_d    = S_FINISH;
          by_abort_d = 1'b1;
        end else if (log_data_valid) begin
          entry_d = log_data;
          idx_d   = C_IDX_LAST;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        // an abort only takes effect once the byte on the bus has been taken
        if (w_xfer) begin
          if (w_abort) begin
            state_d    = S_FINISH;
            by_abort_d = 1'b1;
          end else if (idx_q == '0) begin
            state_d = S_NEXT;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
        end
      end
      S_NEXT: begin
        rem_d  = rem_q - C_ONE;
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (w_abort) begin
          state_d    = S_FINISH;
          by_abort_d = 1'b1;
        end else if (rem_q == C_ONE) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_FINISH: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_byte_sel = '0;
    for (int b = 0; b < NB; b++) begin
      if (idx_d == IDX_W'(b)) begin
        w_byte_sel = entry_d[8*b +: 8];
      end
    end
  end

  // Outputs are decoded from the next state so they are plain flops.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_FINISH);
    aborted_d  = (state_d == S_FINISH) & by_abort_d;
    log_rd_d   = (state_d == S_RD_REQ);
    tx_valid_d = (state_d == S_SEND);
    tx_data_d  = (state_d == S_SEND) ? w_byte_sel : tx_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      entry_q      <= '0;
      idx_q        <= '0;
      abort_pend_q <= 1'b0;
      by_abort_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      log_rd_q     <= 1'b0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      entry_q      <= entry_d;
      idx_q        <= idx_d;
      abort_pend_q <= abort_pend_d;
      by_abort_q   <= by_abort_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      log_rd_q     <= log_rd_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  assign log_addr = addr_q;
  assign log_rd   = log_rd_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;

endmodule

`default_nettype wire

// File: tb/tb_log_uart_dumper.sv
// tb_log_uart_dumper: directed self-checking bench for log_uart_dumper.
`default_nettype none

module tb_log_uart_dumper;

  localparam int AW = 10;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic          abort = 1'b0;
  logic          busy, done, aborted, log_rd, tx_valid;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_data;
  logic          log_data_valid;
  logic [7:0]    tx_data;
  logic          tx_ready = 1'b0;

  logic [DW-1:0] mem [1024];
  logic          bram_en = 1'b1;
  logic          bram_valid = 1'b0;
  logic [DW-1:0] bram_data = '0;
  logic          man_valid = 1'b0;
  logic [DW-1:0] man_data = '0;

  assign log_data_valid = bram_valid | man_valid;
  assign log_data       = man_valid ? man_data : bram_data;

  log_uart_dumper #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .log_addr(log_addr), .log_rd(log_rd), .log_data(log_data),
    .log_data_valid(log_data_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );

  always #10 clk = ~clk;

  // Synchronous BRAM, read latency 1
  always @(posedge clk) begin
    bram_valid <= bram_en && log_rd;
    bram_data  <= mem[log_addr];
  end

  logic [AW-1:0] rd_log [$];
  logic [7:0]    tx_log [$];
  int            txv_cycles = 0;
  int            done_pulses = 0;
  int            stab_bad = 0;
  logic          prev_hold = 1'b0;
  logic [7:0]    prev_byte = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (log_rd) rd_log.push_back(log_addr);
      if (tx_valid) txv_cycles++;
      if (done) done_pulses++;
      if (prev_hold && (tx_valid !== 1'b1 || tx_data !== prev_byte)) stab_bad++;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      prev_hold = tx_valid && !tx_ready;
      prev_byte = tx_data;
    end
  end

  int total = 0;
  int bad = 0;
  int rd0, tx0, tv0, dn0;
  logic got_done, got_aborted;
  logic [7:0] exp_b [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    rd0 = rd_log.size();
    tx0 = tx_log.size();
    tv0 = txv_cycles;
    dn0 = done_pulses;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW:0] n, input logic ab);
    base_addr = b;
    count     = n;
    start     = 1'b1;
    abort     = ab;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  // mode 0: ready held high; 1: random with a 20-cycle stall; 2: untouched
  task automatic wait_done(input int budget, input int mode);
    got_done    = 1'b0;
    got_aborted = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done === 1'b1) begin
        got_done    = 1'b1;
        got_aborted = aborted;
        break;
      end
      if (mode == 0) tx_ready = 1'b1;
      else if (mode == 1) tx_ready = (c >= 4 && c < 24) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
    end
    chk("done_seen", {31'd0, got_done}, 32'd1);
  endtask

  task automatic end_checks(input string tag, input logic exp_ab);
    chk({tag, "_aborted"}, {31'd0, got_aborted}, {31'd0, exp_ab});
    tick();
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_once"}, done_pulses - dn0, 32'd1);
  endtask

  task automatic chk_bytes(input string tag, input int n);
    chk({tag, "_nbytes"}, tx_log.size() - tx0, n);
    for (int k = 0; k < n && (tx0 + k) < tx_log.size(); k++)
      chk($sformatf("%s_b%0d", tag, k), {24'd0, tx_log[tx0+k]}, {24'd0, exp_b[k]});
  endtask

  task automatic set_exp6();
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
    exp_b[3] = 8'h0D; exp_b[4] = 8'h0E; exp_b[5] = 8'h0F;
  endtask

  initial begin
    int errs;
    for (int i = 0; i < 1024; i++) mem[i] = {8'(i), ~8'(i), 8'h3C};

    #5;
    chk("reset_outputs", {9'd0, busy, done, aborted, log_rd, tx_valid, tx_data, log_addr}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Oversized count clamps to the full depth
    snap();
    pulse_start(10'h000, 11'h7FF, 1'b0);
    wait_done(7000, 0);
    chk("clamp_reads", rd_log.size() - rd0, 32'd1024);
    chk("clamp_bytes", tx_log.size() - tx0, 32'd3072);
    errs = 0;
    if (rd_log.size() - rd0 == 1024 && tx_log.size() - tx0 == 3072) begin
      for (int k = 0; k < 1024; k++) begin
        if (rd_log[rd0+k] !== 10'(k)) errs++;
        if (tx_log[tx0+3*k]   !== 8'(k))  errs++;
        if (tx_log[tx0+3*k+1] !== ~8'(k)) errs++;
        if (tx_log[tx0+3*k+2] !== 8'h3C)  errs++;
      end
    end else begin
      errs = 1;
    end
    chk("clamp_content", errs, 32'd0);
    end_checks("clamp", 1'b0);

    mem[10'h005] = 24'hA1B2C3; mem[10'h006] = 24'h0D0E0F;
    mem[10'h3FE] = 24'h111213; mem[10'h3FF] = 24'h212223; mem[10'h000] = 24'h313233;

    // Basic two-entry dump
    snap();
    pulse_start(10'h005, 11'd2, 1'b0);
    wait_done(100, 0);
    chk("basic_nreads", rd_log.size() - rd0, 32'd2);
    chk("basic_rd0", {22'd0, rd_log[rd0]}, 32'h005);
    chk("basic_rd1", {22'd0, rd_log[rd0+1]}, 32'h006);
    set_exp6();
    chk_bytes("basic", 6);
    end_checks("basic", 1'b0);

    // Address wrap
    snap();
    pulse_start(10'h3FE, 11'd3, 1'b0);
    wait_done(100, 0);
    chk("wrap_nreads", rd_log.size() - rd0, 32'd3);
    chk("wrap_rd2", {22'd0, rd_log[rd0+2]}, 32'h000);
    exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13;
    exp_b[3] = 8'h21; exp_b[4] = 8'h22; exp_b[5] = 8'h23;
    exp_b[6] = 8'h31; exp_b[7] = 8'h32; exp_b[8] = 8'h33;
    chk_bytes("wrap", 9);
    end_checks("wrap", 1'b0);

    // count = 0: done one cycle after start, nothing read or sent
    snap();
    pulse_start(10'h005, 11'd0, 1'b0);
    chk("zero_done_now", {31'd0, done}, 32'd1);
    wait_done(5, 0);
    end_checks("zero", 1'b0);
    chk("zero_no_reads", rd_log.size() - rd0, 32'd0);
    chk("zero_no_valid", txv_cycles - tv0, 32'd0);

    // abort coinciding with start in IDLE is not taken
    snap();
    pulse_start(10'h006, 11'd1, 1'b1);
    wait_done(50, 0);
    exp_b[0] = 8'h0D; exp_b[1] = 8'h0E; exp_b[2] = 8'h0F;
    chk_bytes("startab", 3);
    end_checks("startab", 1'b0);

    // Backpressure: same stream, stable while stalled
    snap();
    pulse_start(10'h005, 11'd2, 1'b0);
    wait_done(600, 1);
    set_exp6();
    chk_bytes("bp", 6);
    chk("bp_stable", stab_bad, 32'd0);
    end_checks("bp", 1'b0);

    // Abort while the second byte waits on a stalled transmitter
    tx_ready = 1'b0;
    snap();
    pulse_start(10'h005, 11'd2, 1'b0);
    for (int c = 0; c < 20 && tx_valid !== 1'b1; c++) tick();
    chk("ab_first", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA1});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("ab_second", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hB2});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(); tick(); tick();
    chk("ab_hold", {22'd0, tx_valid, done, tx_data}, {22'd0, 1'b1, 1'b0, 8'hB2});
    tx_ready = 1'b1;
    wait_done(10, 2);
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2;
    chk_bytes("ab", 2);
    chk("ab_nreads", rd_log.size() - rd0, 32'd1);
    end_checks("ab", 1'b1);

    // Abort in RD_WAIT, then a late read-valid
    bram_en = 1'b0;
    snap();
    pulse_start(10'h005, 11'd2, 1'b0);
    chk("rw_rd", {31'd0, log_rd}, 32'd1);
    tick();
    chk("rw_wait", {30'd0, log_rd, tx_valid}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("rw_done", {30'd0, done, aborted}, 32'd3);
    man_data  = 24'hDEAD01;
    man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    tick(); tick();
    chk("rw_no_valid", txv_cycles - tv0, 32'd0);
    chk("rw_idle", {30'd0, busy, done}, 32'd0);
    chk("rw_done_once", done_pulses - dn0, 32'd1);
    bram_en = 1'b1;

    // Reset mid-SEND, then a clean dump
    tx_ready = 1'b0;
    pulse_start(10'h005, 11'd2, 1'b0);
    for (int c = 0; c < 20 && tx_valid !== 1'b1; c++) tick();
    chk("rst_in_send", {31'd0, tx_valid}, 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_outputs_mid", {9'd0, busy, done, aborted, log_rd, tx_valid, tx_data, log_addr}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    snap();
    pulse_start(10'h005, 11'd2, 1'b0);
    wait_done(100, 0);
    set_exp6();
    chk_bytes("post_rst", 6);
    end_checks("post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
